// File: rtl/i2s_codec_if.sv
// I2S master for a WM8731-class codec: derives BCLK/LRCK from the 12 MHz clock,
// shifts out stereo DAC pairs and captures stereo ADC pairs, gated by PLL lock.
module i2s_codec_if #(
    parameter int DATA_W    = 24,
    parameter int SLOT_W    = 32,
    parameter int BCLK_HALF = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pll_locked,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_left,
    input  logic [DATA_W-1:0] tx_right,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_left,
    output logic [DATA_W-1:0] rx_right,
    output logic              aud_bclk,
    output logic              aud_daclrck,
    output logic              aud_adclrck,
    output logic              aud_dacdat,
    input  logic              aud_adcdat,
    output logic              underflow,
    input  logic              underflow_clr,
    output logic              running
);
    localparam int BC_W  = $clog2(2 * SLOT_W);
    localparam int DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;

    localparam logic [BC_W-1:0]  BIT_LAST = BC_W'(2 * SLOT_W - 1);
    localparam logic [BC_W-1:0]  SLOT_B   = BC_W'(SLOT_W);
    localparam logic [BC_W-1:0]  L_END    = BC_W'(DATA_W);
    localparam logic [BC_W-1:0]  R_START  = BC_W'(SLOT_W + 1);
    localparam logic [BC_W-1:0]  R_END    = BC_W'(SLOT_W + DATA_W);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);

    localparam logic [0:0] ST_WAIT_LOCK = 1'b0;
    localparam logic [0:0] ST_RUN       = 1'b1;

    logic              lock_meta_q, lock_sync_q;
    logic [0:0]        state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              bclk_q, bclk_d;
    logic [BC_W-1:0]   bit_q, bit_d;
    logic              lrck_q, lrck_d;
    logic              dac_q, dac_d;
    logic [DATA_W-1:0] tx_sh_l_q, tx_sh_l_d, tx_sh_r_q, tx_sh_r_d;
    logic              hold_full_q, hold_full_d;
    logic [DATA_W-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
    logic              uf_q, uf_d;
    logic [DATA_W-1:0] rx_sh_l_q, rx_sh_l_d, rx_sh_r_q, rx_sh_r_d;
    logic              rx_valid_q, rx_valid_d;
    logic [DATA_W-1:0] rx_l_q, rx_l_d, rx_r_q, rx_r_d;

    logic              div_wrap, bclk_fall, bclk_rise, accept;
    logic [BC_W-1:0]   bit_next;

    assign running     = (state_q == ST_RUN);
    assign tx_ready    = running & ~hold_full_q;
    assign accept      = tx_valid & tx_ready;
    assign div_wrap    = (div_q == DIV_LAST);
    assign bclk_fall   = div_wrap & bclk_q;
    assign bclk_rise   = div_wrap & ~bclk_q;
    assign bit_next    = (bit_q == BIT_LAST) ? '0 : bit_q + BC_W'(1);

    assign aud_bclk    = bclk_q;
    assign aud_daclrck = lrck_q;
    assign aud_adclrck = lrck_q;
    assign aud_dacdat  = dac_q;
    assign underflow   = uf_q;
    assign rx_valid    = rx_valid_q;
    assign rx_left     = rx_l_q;
    assign rx_right    = rx_r_q;

    // Two-flop synchronizer for the asynchronous PLL lock indicator
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
        end else begin
            lock_meta_q <= pll_locked;
            lock_sync_q <= lock_meta_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        bclk_d      = bclk_q;
        bit_d       = bit_q;
        lrck_d      = lrck_q;
        dac_d       = dac_q;
        tx_sh_l_d   = tx_sh_l_q;
        tx_sh_r_d   = tx_sh_r_q;
        hold_full_d = hold_full_q;
        hold_l_d    = hold_l_q;
        hold_r_d    = hold_r_q;
        uf_d        = uf_q;
        rx_sh_l_d   = rx_sh_l_q;
        rx_sh_r_d   = rx_sh_r_q;
        rx_valid_d  = 1'b0;
        rx_l_d      = rx_l_q;
        rx_r_d      = rx_r_q;

        case (state_q)
            ST_WAIT_LOCK: begin
                if (lock_sync_q) begin
                    state_d = ST_RUN;
                    div_d   = '0;
                    bit_d   = BIT_LAST;
                    bclk_d  = 1'b0;
                end
            end
            default: begin
                if (!lock_sync_q) begin
                    // Lock lost: everything returns to its reset value
                    state_d     = ST_WAIT_LOCK;
                    div_d       = '0;
                    bclk_d      = 1'b0;
                    bit_d       = BIT_LAST;
                    lrck_d      = 1'b1;
                    dac_d       = 1'b0;
                    tx_sh_l_d   = '0;
                    tx_sh_r_d   = '0;
                    hold_full_d = 1'b0;
                    uf_d        = 1'b0;
                    rx_sh_l_d   = '0;
                    rx_sh_r_d   = '0;
                    rx_l_d      = '0;
                    rx_r_d      = '0;
                end else begin
                    div_d = div_wrap ? '0 : div_q + DIV_W'(1);
                    if (div_wrap) bclk_d = ~bclk_q;
                    if (underflow_clr) uf_d = 1'b0;
                    if (accept) begin
                        hold_full_d = 1'b1;
                        hold_l_d    = tx_left;
                        hold_r_d    = tx_right;
                    end
                    // Falling edge: advance bit position, drive next DAC bit (one-bit I2S delay)
                    if (bclk_fall) begin
                        bit_d  = bit_next;
                        lrck_d = (bit_next >= SLOT_B);
                        dac_d  = 1'b0;
                        if (bit_next == '0) begin
                            if (hold_full_q) begin
                                tx_sh_l_d   = hold_l_q;
                                tx_sh_r_d   = hold_r_q;
                                hold_full_d = 1'b0;
                            end else begin
                                tx_sh_l_d = '0;
                                tx_sh_r_d = '0;
                                uf_d      = 1'b1;
                            end
                        end else if (bit_next <= L_END) begin
                            dac_d     = tx_sh_l_q[DATA_W-1];
                            tx_sh_l_d = tx_sh_l_q << 1;
                        end else if (bit_next >= R_START && bit_next <= R_END) begin
                            dac_d     = tx_sh_r_q[DATA_W-1];
                            tx_sh_r_d = tx_sh_r_q << 1;
                        end
                    end
                    if (bclk_rise) begin
                        if (bit_q != '0 && bit_q <= L_END) begin
                            rx_sh_l_d = {rx_sh_l_q[DATA_W-2:0], aud_adcdat};
                        end else if (bit_q >= R_START && bit_q <= R_END) begin
                            rx_sh_r_d = {rx_sh_r_q[DATA_W-2:0], aud_adcdat};
                        end
                        if (bit_q == R_END) begin
                            rx_valid_d = 1'b1;
                            rx_l_d     = rx_sh_l_q;
                            rx_r_d     = {rx_sh_r_q[DATA_W-2:0], aud_adcdat};
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_WAIT_LOCK;
            div_q       <= '0;
            bclk_q      <= 1'b0;
            bit_q       <= BIT_LAST;
            lrck_q      <= 1'b1;
            dac_q       <= 1'b0;
            tx_sh_l_q   <= '0;
            tx_sh_r_q   <= '0;
            hold_full_q <= 1'b0;
            hold_l_q    <= '0;
            hold_r_q    <= '0;
            uf_q        <= 1'b0;
            rx_sh_l_q   <= '0;
            rx_sh_r_q   <= '0;
            rx_valid_q  <= 1'b0;
            rx_l_q      <= '0;
            rx_r_q      <= '0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bclk_q      <= bclk_d;
            bit_q       <= bit_d;
            lrck_q      <= lrck_d;
            dac_q       <= dac_d;
            tx_sh_l_q   <= tx_sh_l_d;
            tx_sh_r_q   <= tx_sh_r_d;
            hold_full_q <= hold_full_d;
            hold_l_q    <= hold_l_d;
            hold_r_q    <= hold_r_d;
            uf_q        <= uf_d;
            rx_sh_l_q   <= rx_sh_l_d;
            rx_sh_r_q   <= rx_sh_r_d;
            rx_valid_q  <= rx_valid_d;
            rx_l_q      <= rx_l_d;
            rx_r_q      <= rx_r_d;
        end
    end
endmodule

// File: tb/tb_i2s_codec_if.sv
// Bench for i2s_codec_if: DAC data looped back to ADC, accepted pairs queued and
// matched against captured pairs, plus lock, framing and underflow behaviour.
`timescale 1ns/1ps
module tb_i2s_codec_if;
    localparam int DATA_W = 24;
    localparam logic [55:0] RST_VEC = {2'b00, 48'h0, 6'b011000};

    logic              clk, reset_n, pll_locked, tx_valid, underflow_clr;
    logic [DATA_W-1:0] tx_left, tx_right, rx_left, rx_right;
    logic              tx_ready, rx_valid, aud_bclk, aud_daclrck, aud_adclrck;
    logic              aud_dacdat, aud_adcdat, underflow, running;

    int                n_checks = 0;
    int                n_fail = 0;
    logic [2*DATA_W-1:0] sb_q[$];
    logic              rx_hit;
    logic [2*DATA_W-1:0] rx_got, rx_exp;

    assign aud_adcdat = aud_dacdat;

    i2s_codec_if dut (
        .clk(clk), .reset_n(reset_n), .pll_locked(pll_locked),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_left(tx_left), .tx_right(tx_right),
        .rx_valid(rx_valid), .rx_left(rx_left), .rx_right(rx_right),
        .aud_bclk(aud_bclk), .aud_daclrck(aud_daclrck), .aud_adclrck(aud_adclrck),
        .aud_dacdat(aud_dacdat), .aud_adcdat(aud_adcdat),
        .underflow(underflow), .underflow_clr(underflow_clr), .running(running)
    );

    initial clk = 1'b0;
    always #42 clk = ~clk;

    function automatic logic [55:0] out_vec();
        return {tx_ready, rx_valid, rx_left, rx_right, aud_bclk, aud_daclrck,
                aud_adclrck, aud_dacdat, underflow, running};
    endfunction

    // One clk: record an accept about to happen, then observe at the falling edge
    task automatic step();
        if (tx_valid && tx_ready) sb_q.push_back({tx_left, tx_right});
        @(posedge clk);
        @(negedge clk);
        rx_hit = rx_valid;
        rx_got = {rx_left, rx_right};
        if (rx_valid) begin
            if (sb_q.size() > 0) rx_exp = sb_q.pop_front();
            else rx_exp = '0;
        end
    endtask

    task automatic test_reset();
        int bad;
        logic [55:0] first_bad;
        reset_n = 1'b0; pll_locked = 1'b0; tx_valid = 1'b0; underflow_clr = 1'b0;
        tx_left = '0; tx_right = '0;
        repeat (3) step();
        n_checks++;
        if (out_vec() !== RST_VEC)
            $display("[TB] FAIL reset_asserted: got %h expected %h", out_vec(), RST_VEC);
        if (out_vec() !== RST_VEC) n_fail++;
        reset_n = 1'b1;
        bad = 0;
        first_bad = '0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (out_vec() !== RST_VEC) begin
                if (bad == 0) first_bad = out_vec();
                bad++;
            end
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("[TB] FAIL reset_hold: %0d bad cycles, first %h expected %h", bad, first_bad, RST_VEC);
        end
    endtask

    task automatic test_startup();
        int n, t, highs, rises, last_rise, bclk_bad, lr_diff, rx_n;
        logic prev_b, prev_l;
        tx_left = 24'hA5A5A5; tx_right = 24'h5A5A5A; tx_valid = 1'b1;
        pll_locked = 1'b1;
        n = 0;
        while (running !== 1'b1 && n < 10) begin step(); n++; end
        n_checks++;
        if (running !== 1'b1 || n < 2 || n > 3) begin
            n_fail++;
            $display("[TB] FAIL lock_to_run: running=%b after %0d clk, expected 1 after 2..3", running, n);
        end
        n_checks++;
        if (tx_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL tx_ready_on_run: got %b expected 1", tx_ready);
        end
        n = 0;
        while (aud_daclrck !== 1'b0 && n < 20) begin step(); n++; end
        n_checks++;
        if (n != 4) begin
            n_fail++;
            $display("[TB] FAIL first_lrck_fall: %0d clk after run, expected 4", n);
        end
        t = 0; highs = 0; rises = 0; last_rise = -1; bclk_bad = 0; lr_diff = 0; rx_n = 0;
        prev_b = aud_bclk; prev_l = aud_daclrck;
        while (t < 400) begin
            step();
            t++;
            if (rx_hit) begin
                rx_n++;
                n_checks++;
                if (rx_got !== rx_exp) begin
                    n_fail++;
                    $display("[TB] FAIL startup_rx: got %h expected %h", rx_got, rx_exp);
                end
            end
            if (aud_adclrck !== aud_daclrck) lr_diff++;
            if (t == 4) begin
                n_checks++;
                if (aud_dacdat !== 1'b1) begin
                    n_fail++;
                    $display("[TB] FAIL left_msb: got %b expected 1", aud_dacdat);
                end
            end
            if (t == 8) begin
                n_checks++;
                if (aud_dacdat !== 1'b0) begin
                    n_fail++;
                    $display("[TB] FAIL left_bit22: got %b expected 0", aud_dacdat);
                end
            end
            if (prev_b === 1'b0 && aud_bclk === 1'b1) begin
                if (last_rise >= 0 && t - last_rise != 4) bclk_bad++;
                last_rise = t;
                rises++;
            end
            if (prev_l === 1'b1 && aud_daclrck === 1'b0) break;
            if (aud_daclrck === 1'b1) highs++;
            prev_b = aud_bclk;
            prev_l = aud_daclrck;
        end
        n_checks++;
        if (t != 256) begin n_fail++; $display("[TB] FAIL lrck_period: got %0d expected 256", t); end
        n_checks++;
        if (highs != 128) begin n_fail++; $display("[TB] FAIL lrck_duty: high %0d expected 128", highs); end
        n_checks++;
        if (bclk_bad != 0 || rises != 64) begin
            n_fail++;
            $display("[TB] FAIL bclk_period: %0d rises (expected 64), %0d not 4 clk apart (expected 0)", rises, bclk_bad);
        end
        n_checks++;
        if (lr_diff != 0) begin n_fail++; $display("[TB] FAIL adclrck_eq: %0d differing clk, expected 0", lr_diff); end
        n_checks++;
        if (rx_n != 1) begin n_fail++; $display("[TB] FAIL first_frame_rx: %0d pulses expected 1", rx_n); end
    endtask

    task automatic test_loopback();
        int rx_n, last, bad;
        rx_n = 0; last = -1; bad = 0;
        for (int n = 0; n < 900 && rx_n < 3; n++) begin
            step();
            if (rx_hit) begin
                n_checks++;
                if (rx_got !== rx_exp) begin
                    n_fail++;
                    $display("[TB] FAIL loop_sb: got %h expected %h", rx_got, rx_exp);
                end
                n_checks++;
                if (rx_got !== {24'hA5A5A5, 24'h5A5A5A}) begin
                    n_fail++;
                    $display("[TB] FAIL loop_pattern: got %h expected a5a5a55a5a5a", rx_got);
                end
                if (last >= 0 && n - last != 256) bad++;
                last = n;
                rx_n++;
            end
        end
        n_checks++;
        if (rx_n != 3 || bad != 0) begin
            n_fail++;
            $display("[TB] FAIL rx_interval: %0d pulses (expected 3), %0d gaps not 256 clk (expected 0)", rx_n, bad);
        end
    endtask

    task automatic test_underflow();
        int n, dac_bad, highs;
        tx_valid = 1'b0;
        n = 0;
        while (sb_q.size() > 0 && n < 800) begin
            step();
            n++;
            if (rx_hit) begin
                n_checks++;
                if (rx_got !== rx_exp) begin
                    n_fail++;
                    $display("[TB] FAIL drain_rx: got %h expected %h", rx_got, rx_exp);
                end
            end
        end
        n_checks++;
        if (sb_q.size() != 0) begin n_fail++; $display("[TB] FAIL drain_timeout: %0d pairs left, expected 0", sb_q.size()); end
        n_checks++;
        if (underflow !== 1'b0) begin n_fail++; $display("[TB] FAIL no_early_uf: got %b expected 0", underflow); end
        dac_bad = 0;
        for (int i = 0; i < 600; i++) begin
            step();
            if (aud_dacdat !== 1'b0) dac_bad++;
            if (rx_hit) begin
                n_checks++;
                if (rx_got !== '0) begin n_fail++; $display("[TB] FAIL empty_rx: got %h expected 0", rx_got); end
            end
        end
        n_checks++;
        if (dac_bad != 0) begin n_fail++; $display("[TB] FAIL dac_idle: %0d nonzero clk, expected 0", dac_bad); end
        n_checks++;
        if (underflow !== 1'b1) begin n_fail++; $display("[TB] FAIL uf_set: got %b expected 1", underflow); end
        n = 0;
        do begin step(); n++; end while (!rx_hit && n < 300);
        n_checks++;
        if (!rx_hit) begin n_fail++; $display("[TB] FAIL uf_sync_timeout: no rx_valid in %0d clk", n); end
        underflow_clr = 1'b1;
        step();
        underflow_clr = 1'b0;
        n_checks++;
        if (underflow !== 1'b0) begin n_fail++; $display("[TB] FAIL uf_clr: got %b expected 0", underflow); end
        repeat (20) step();
        n_checks++;
        if (underflow !== 1'b0) begin n_fail++; $display("[TB] FAIL uf_stays_clr: got %b expected 0", underflow); end
        n = 0;
        do begin step(); n++; end while (!rx_hit && n < 300);
        n_checks++;
        if (!rx_hit || underflow !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL uf_reset_next_frame: rx=%b uf=%b expected 1 1", rx_hit, underflow);
        end
        underflow_clr = 1'b1;
        step();
        highs = 0;
        for (int i = 0; i < 256; i++) begin
            step();
            if (underflow === 1'b1) highs++;
        end
        underflow_clr = 1'b0;
        n_checks++;
        if (highs != 1) begin n_fail++; $display("[TB] FAIL uf_set_priority: high %0d clk expected 1", highs); end
    endtask

    task automatic test_back_to_back();
        int n, k, rx_k, acc_in, acc_bad, rdy_bad;
        logic will_acc;
        n = 0;
        do begin step(); n++; end while (!rx_hit && n < 300);
        n_checks++;
        if (!rx_hit) begin n_fail++; $display("[TB] FAIL b2b_sync_timeout: no rx_valid in %0d clk", n); end
        k = 0; rx_k = 0; acc_in = 0; acc_bad = 0; rdy_bad = 0;
        tx_left = 24'h100000; tx_right = 24'h200000; tx_valid = 1'b1;
        for (int i = 0; i < 3000 && rx_k < 10; i++) begin
            will_acc = tx_ready;
            step();
            if (will_acc) begin
                acc_in++;
                k++;
                tx_left = 24'(24'h100000 + k);
                tx_right = 24'(24'h200000 + k);
                if (tx_ready !== 1'b0) rdy_bad++;
            end
            if (rx_hit) begin
                n_checks++;
                if (rx_got !== rx_exp) begin
                    n_fail++;
                    $display("[TB] FAIL b2b_sb: got %h expected %h", rx_got, rx_exp);
                end
                n_checks++;
                if (rx_got !== {24'(24'h100000 + rx_k), 24'(24'h200000 + rx_k)}) begin
                    n_fail++;
                    $display("[TB] FAIL b2b_seq: pair %0d got %h expected %h%h", rx_k, rx_got,
                             24'(24'h100000 + rx_k), 24'(24'h200000 + rx_k));
                end
                if (rx_k > 0 && acc_in != 1) acc_bad++;
                acc_in = 0;
                rx_k++;
            end
        end
        n_checks++;
        if (rx_k != 10) begin n_fail++; $display("[TB] FAIL b2b_count: %0d pairs expected 10", rx_k); end
        n_checks++;
        if (acc_bad != 0 || rdy_bad != 0) begin
            n_fail++;
            $display("[TB] FAIL one_accept_per_frame: %0d bad frames, %0d ready-after-accept (expected 0 0)", acc_bad, rdy_bad);
        end
        tx_valid = 1'b0;
        n = 0;
        while (sb_q.size() > 0 && n < 800) begin
            step();
            n++;
            if (rx_hit) begin
                n_checks++;
                if (rx_got !== rx_exp) begin n_fail++; $display("[TB] FAIL b2b_drain: got %h expected %h", rx_got, rx_exp); end
            end
        end
        n_checks++;
        if (sb_q.size() != 0) begin n_fail++; $display("[TB] FAIL b2b_drain_timeout: %0d left expected 0", sb_q.size()); end
    endtask

    task automatic test_relock();
        int n, dac_bad;
        n = 0;
        do begin step(); n++; end while (!rx_hit && n < 300);
        repeat (208) step();
        pll_locked = 1'b0;
        n = 0;
        while (running !== 1'b0 && n < 10) begin step(); n++; end
        n_checks++;
        if (running !== 1'b0 || n > 3) begin
            n_fail++;
            $display("[TB] FAIL unlock_latency: running=%b after %0d clk, expected 0 within 3", running, n);
        end
        n_checks++;
        if (out_vec() !== RST_VEC) begin n_fail++; $display("[TB] FAIL unlock_outputs: got %h expected %h", out_vec(), RST_VEC); end
        repeat (20) step();
        n_checks++;
        if (out_vec() !== RST_VEC) begin n_fail++; $display("[TB] FAIL unlock_hold: got %h expected %h", out_vec(), RST_VEC); end
        pll_locked = 1'b1;
        n = 0;
        while (running !== 1'b1 && n < 10) begin step(); n++; end
        n = 0;
        while (aud_daclrck !== 1'b0 && n < 20) begin step(); n++; end
        n_checks++;
        if (n != 4) begin n_fail++; $display("[TB] FAIL relock_frame_start: %0d clk, expected 4", n); end
        n_checks++;
        if (underflow !== 1'b1) begin n_fail++; $display("[TB] FAIL relock_uf: got %b expected 1", underflow); end
        dac_bad = 0;
        n = 0;
        do begin
            step();
            n++;
            if (aud_dacdat !== 1'b0) dac_bad++;
        end while (!rx_hit && n < 300);
        n_checks++;
        if (!rx_hit || rx_got !== '0 || dac_bad != 0) begin
            n_fail++;
            $display("[TB] FAIL relock_zero_frame: rx=%b pair %h dac_nonzero=%0d expected 1 0 0", rx_hit, rx_got, dac_bad);
        end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_loopback();
        test_underflow();
        test_back_to_back();
        test_relock();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/i2s_codec_if.md
Name: i2s_codec_if

Overview:
- I2S master serial interface between the audio datapath and the WM8731-class codec.
- Clocked by the 12 MHz audio PLL output clock. The same 12 MHz clock drives the codec MCLK directly; this block does not generate MCLK.
- Derives BCLK/LRCK, serializes stereo DAC samples and deserializes stereo ADC samples.
- Holds off all activity until the PLL lock indicator is synchronized high.

Parameters:
- DATA_W, 24, sample width per channel; must satisfy DATA_W <= SLOT_W-1.
- SLOT_W, 32, BCLK periods per channel slot; one frame = 2*SLOT_W BCLK periods.
- BCLK_HALF, 2, clk cycles per BCLK half-period; BCLK = clk/(2*BCLK_HALF).

Ports:
- clk  in  1  12 MHz PLL output clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- pll_locked  in  1  PLL lock, asynchronous to clk; synchronized internally with 2 flops.
- tx_valid  in  1  DAC sample pair offered.
- tx_ready  out  1  DAC sample pair accepted when tx_valid & tx_ready.
- tx_left  in  DATA_W  left DAC sample.
- tx_right  in  DATA_W  right DAC sample.
- rx_valid  out  1  one-clk pulse: ADC pair valid.
- rx_left  out  DATA_W  left ADC sample.
- rx_right  out  DATA_W  right ADC sample.
- aud_bclk  out  1  bit clock.
- aud_daclrck  out  1  DAC LR clock.
- aud_adclrck  out  1  ADC LR clock, identical to aud_daclrck.
- aud_dacdat  out  1  serial DAC data.
- aud_adcdat  in  1  serial ADC data.
- underflow  out  1  sticky: a frame started with no DAC sample held.
- underflow_clr  in  1  clears underflow.
- running  out  1  high in RUN state.

Behaviour:
- Reset values: aud_bclk=0, LRCKs=1, aud_dacdat=0, tx_ready=0, rx_valid=0, rx_left=rx_right=0, underflow=0, running=0. Hold register is empty.
- State WAIT_LOCK to RUN: taken when the synchronized lock is 1, i.e. 2 clk after pll_locked rises.
- On entering RUN: div_cnt=0, bit_cnt=2*SLOT_W-1, bclk=0.
- State RUN to WAIT_LOCK: taken when the synchronized lock is 0. All outputs and the hold register return to reset values on the next clk.
- Divider: div_cnt counts 0..BCLK_HALF-1; aud_bclk toggles on wrap.
  - bit_cnt increments modulo 2*SLOT_W on each BCLK falling edge.
- LRCK: 0 while bit_cnt < SLOT_W (left slot), 1 otherwise. Updates on the falling edge, together with bit_cnt.
- DAC output: aud_dacdat updates on BCLK falling edges (I2S, one-bit delay).
  - bit_cnt=k+1, k in 0..DATA_W-1: left[DATA_W-1-k].
  - bit_cnt=SLOT_W+k+1: right[DATA_W-1-k].
  - All other bit positions: 0.
- Frame start is the falling edge where bit_cnt becomes 0.
  - Hold full: the shift register loads the held pair and hold becomes empty.
  - Hold empty: the shift register loads zeros and underflow is set.
- Hold register: single entry; tx_ready = running & hold empty.
  - An accept on the frame-start clk while hold is empty counts as underflow; the new pair enters hold for the next frame.
- underflow: set has priority over underflow_clr in the same clk.
- ADC capture: aud_adcdat is sampled on each BCLK rising edge.
  - bit_cnt=k+1 gives left bit DATA_W-1-k; bit_cnt=SLOT_W+k+1 gives right bit DATA_W-1-k.
  - Rising edges in padding bits are ignored.
- rx_valid: high for exactly 1 clk, on the clk after the rising edge at bit_cnt=SLOT_W+DATA_W.
  - rx_left and rx_right update in that same clk and are held until the next pulse.
  - There is no backpressure on the rx side.
- Rates at defaults: BCLK period 4 clk (3 MHz); frame 256 clk (46.875 kHz).

Test Plan:
1. Reset asserted, then released with pll_locked=0 for 1000 clk -> every output stays at its reset value; tx_ready=0.
2. pll_locked rises -> running=1 exactly 2-3 clk later; first LRCK falling edge 4 clk after entering RUN. Then BCLK period 4 clk, LRCK period 256 clk, duty 50%.
3. Loopback aud_dacdat->aud_adcdat, tx_left=24'hA5A5A5, tx_right=24'h5A5A5A written before the first frame -> MSB appears on the falling edge one BCLK after LRCK. rx_valid pulses once per 256 clk with rx_left=24'hA5A5A5, rx_right=24'h5A5A5A.
4. tx_valid held low -> aud_dacdat constantly 0, underflow=1 after the first frame start. Pulse underflow_clr -> underflow=0 until the next empty frame start.
5. tx_valid held high with an incrementing pair -> one accept per frame. tx_ready drops for the rest of the frame after each accept; no samples are lost or duplicated over 10 frames.
6. pll_locked dropped mid-right-slot -> within 3 clk all outputs return to reset values. Relock -> the frame restarts at bit_cnt 0 and the first frame carries zeros with underflow=1.
